// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the dual-issue data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef logic slot_t;
  localparam slot_t SLOT0 = 1'b0;
  localparam slot_t SLOT1 = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_GRANT0 = 2'd1;
  localparam state_t ST_GRANT1 = 2'd2;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    slot_t              slot;
  } cmd_t;

  localparam cmd_t CMD_RESET = '{we: 1'b0, addr: {DMEM_AW{1'b0}}, wdata: {DMEM_DW{1'b0}}, slot: SLOT0};

  // Memory is word addressed; the byte offset never reaches Data_MEM.
  function automatic logic [DMEM_AW-1:0] word_align(input logic [DMEM_AW-1:0] a);
    return {a[DMEM_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Per-slot request/response bundle between an issue slot and the arbiter.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way grant logic. With DMEM_ARB_RR_EN defined, contended grants alternate
// via rr_ptr; otherwise slot 0 (the older instruction) always wins.
module rr_arb2 (
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_r;
  logic contended_s;

  assign contended_s = valid0 & valid1;

  // Grant selection: rr_ptr decides only when both slots request.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (contended_s) begin
      grant0 = ~rr_ptr_r;
      grant1 = rr_ptr_r;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

  // Round-robin pointer flips after every contended grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= 1'b0;
    end else if (contended_s) begin
      rr_ptr_r <= ~rr_ptr_r;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority in program order.
  always_comb begin
    grant0 = valid0;
    grant1 = valid1 & ~valid0;
  end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises both issue slots onto the single-ported data memory through a
// command stage and a response stage. Optional round-robin: DMEM_ARB_RR_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic                      clk,
  input  logic                      reset,
  dmem_port_arbiter_if.slave        slot0,
  dmem_port_arbiter_if.slave        slot1,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata,
  output logic                      stall0,
  output logic                      stall1,
  output logic                      busy
);

  logic    grant0_s;
  logic    grant1_s;
  logic    accept_s;
  cmd_t    sel_cmd_s;
  cmd_t    cmd_r;
  logic    cmd_valid_r;
  logic    mem_we_r;
  logic    rsp0_valid_r;
  logic    rsp1_valid_r;
  logic [DW-1:0] rsp0_rdata_r;
  logic [DW-1:0] rsp1_rdata_r;
  state_t  state_r;
  state_t  state_nxt_s;

  rr_arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .valid0 (slot0.valid),
    .valid1 (slot1.valid),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  assign accept_s        = grant0_s | grant1_s;
  assign slot0.ready     = grant0_s;
  assign slot1.ready     = grant1_s;
  assign stall0          = slot0.valid & ~grant0_s;
  assign stall1          = slot1.valid & ~grant1_s;
  assign slot0.rsp_valid = rsp0_valid_r;
  assign slot0.rsp_rdata = rsp0_rdata_r;
  assign slot1.rsp_valid = rsp1_valid_r;
  assign slot1.rsp_rdata = rsp1_rdata_r;
  assign mem_we          = mem_we_r;
  assign mem_addr        = cmd_r.addr;
  assign mem_wdata       = cmd_r.wdata;
  assign busy            = cmd_valid_r | rsp0_valid_r | rsp1_valid_r;

  // Command mux: pick the granted slot's request.
  always_comb begin
    sel_cmd_s = CMD_RESET;
    if (grant1_s) begin
      sel_cmd_s.we    = slot1.we;
      sel_cmd_s.addr  = word_align(slot1.addr);
      sel_cmd_s.wdata = slot1.wdata;
      sel_cmd_s.slot  = SLOT1;
    end else begin
      sel_cmd_s.we    = slot0.we;
      sel_cmd_s.addr  = word_align(slot0.addr);
      sel_cmd_s.wdata = slot0.wdata;
      sel_cmd_s.slot  = SLOT0;
    end
  end

  // Command (access) stage; address and data hold between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      cmd_r       <= CMD_RESET;
    end else begin
      cmd_valid_r <= accept_s;
      mem_we_r    <= accept_s & sel_cmd_s.we;
      if (accept_s) begin
        cmd_r <= sel_cmd_s;
      end else begin
        cmd_r <= cmd_r;
      end
    end
  end

  // Response stage: capture read data at the end of the access cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= {DW{1'b0}};
      rsp1_rdata_r <= {DW{1'b0}};
    end else begin
      rsp0_valid_r <= cmd_valid_r & (cmd_r.slot == SLOT0);
      rsp1_valid_r <= cmd_valid_r & (cmd_r.slot == SLOT1);
      if (cmd_valid_r && (cmd_r.slot == SLOT0)) begin
        rsp0_rdata_r <= cmd_r.we ? {DW{1'b0}} : mem_rdata;
      end else begin
        rsp0_rdata_r <= rsp0_rdata_r;
      end
      if (cmd_valid_r && (cmd_r.slot == SLOT1)) begin
        rsp1_rdata_r <= cmd_r.we ? {DW{1'b0}} : mem_rdata;
      end else begin
        rsp1_rdata_r <= rsp1_rdata_r;
      end
    end
  end

  // Grant-tracking FSM: records which slot owns the access stage.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_GRANT0, ST_GRANT1: begin
        if (accept_s) begin
          state_nxt_s = grant1_s ? ST_GRANT1 : ST_GRANT0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a cycle-scheduled reference model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int NC = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall0, stall1, busy;
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_port_arbiter_if s0 ();
  dmem_port_arbiter_if s1 ();

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset), .slot0(s0), .slot1(s1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall0(stall0), .stall1(stall1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data_MEM stand-in: 64 words, index wraps on the low address bits.
  logic [31:0] env_mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'd0;
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr[7:2]] <= mem_wdata;
    else if (pl_en) env_mem[pl_idx] <= pl_data;
  end

  task automatic idle_inputs();
    s0.valid = 1'b0; s0.we = 1'b0; s0.addr = 32'd0; s0.wdata = 32'd0;
    s1.valid = 1'b0; s1.we = 1'b0; s1.addr = 32'd0; s1.wdata = 32'd0;
  endtask

  task automatic preload_mem();
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = 32'hA500_0000 + 32'(i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    preload_mem();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    preload_mem();
    @(negedge clk);
    n_cmp++; if ({s0.ready, s1.ready, stall0, stall1, busy} !== 5'b0) begin n_err++; $display("FAIL rst_ctrl got=%b exp=00000", {s0.ready, s1.ready, stall0, stall1, busy}); end
    n_cmp++; if ({s0.rsp_valid, s1.rsp_valid, mem_we} !== 3'b0) begin n_err++; $display("FAIL rst_valids got=%b exp=000", {s0.rsp_valid, s1.rsp_valid, mem_we}); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_err++; $display("FAIL rst_membus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    n_cmp++; if (s0.rsp_rdata !== 32'd0 || s1.rsp_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got=%h/%h exp=0/0", s0.rsp_rdata, s1.rsp_rdata); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_load();
    pl_en = 1'b1; pl_idx = 6'd4; pl_data = 32'hCAFE_0001;
    @(posedge clk); #1; pl_en = 1'b0;
    s0.valid = 1'b1; s0.we = 1'b0; s0.addr = 32'h10;
    @(negedge clk);
    n_cmp++; if (s0.ready !== 1'b1 || stall0 !== 1'b0 || s1.ready !== 1'b0) begin n_err++; $display("FAIL t1_accept got=%b%b%b exp=100", s0.ready, stall0, s1.ready); end
    @(posedge clk); #1; s0.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 32'h10 || busy !== 1'b1) begin n_err++; $display("FAIL t1_access got=%b/%h/%b exp=0/10/1", mem_we, mem_addr, busy); end
    n_cmp++; if (s0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_rsp got=%b exp=0", s0.rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (s0.rsp_valid !== 1'b1 || s0.rsp_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL t1_rsp got=%b/%h exp=1/cafe0001", s0.rsp_valid, s0.rsp_rdata); end
    n_cmp++; if (s1.rsp_valid !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL t1_other got=%b/%b exp=0/0", s1.rsp_valid, mem_we); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (s0.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_done got=%b/%b exp=0/0", s0.rsp_valid, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_both_loads();
    s0.valid = 1'b1; s0.we = 1'b0; s0.addr = 32'h20;
    s1.valid = 1'b1; s1.we = 1'b0; s1.addr = 32'h24;
    @(negedge clk);
    n_cmp++; if ({s0.ready, s1.ready, stall0, stall1} !== 4'b1001) begin n_err++; $display("FAIL t2_cycle_n got=%b exp=1001", {s0.ready, s1.ready, stall0, stall1}); end
    @(posedge clk); #1; s0.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({s0.ready, s1.ready, stall1} !== 3'b010 || mem_addr !== 32'h20) begin n_err++; $display("FAIL t2_cycle_n1 got=%b/%h exp=010/20", {s0.ready, s1.ready, stall1}, mem_addr); end
    @(posedge clk); #1; s1.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (s0.rsp_valid !== 1'b1 || s0.rsp_rdata !== 32'hA500_0008 || mem_addr !== 32'h24) begin n_err++; $display("FAIL t2_rsp0 got=%b/%h/%h exp=1/a5000008/24", s0.rsp_valid, s0.rsp_rdata, mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (s1.rsp_valid !== 1'b1 || s1.rsp_rdata !== 32'hA500_0009 || s0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t2_rsp1 got=%b/%h/%b exp=1/a5000009/0", s1.rsp_valid, s1.rsp_rdata, s0.rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    s0.valid = 1'b1; s0.we = 1'b1; s0.addr = 32'h40; s0.wdata = 32'h55;
    @(negedge clk);
    n_cmp++; if (s0.ready !== 1'b1) begin n_err++; $display("FAIL t3_st_ready got=%b exp=1", s0.ready); end
    @(posedge clk); #1;
    s0.valid = 1'b0; s1.valid = 1'b1; s1.we = 1'b0; s1.addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h55) begin n_err++; $display("FAIL t3_write got=%b/%h/%h exp=1/40/55", mem_we, mem_addr, mem_wdata); end
    n_cmp++; if (s1.ready !== 1'b1) begin n_err++; $display("FAIL t3_ld_ready got=%b exp=1", s1.ready); end
    @(posedge clk); #1; s1.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (s0.rsp_valid !== 1'b1 || s0.rsp_rdata !== 32'd0 || mem_we !== 1'b0) begin n_err++; $display("FAIL t6_store_rsp got=%b/%h/%b exp=1/0/0", s0.rsp_valid, s0.rsp_rdata, mem_we); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (s1.rsp_valid !== 1'b1 || s1.rsp_rdata !== 32'h55) begin n_err++; $display("FAIL t3_load_back got=%b/%h exp=1/55", s1.rsp_valid, s1.rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int exp_g;
    int run0 = 0;
    int run1 = 0;
    int a0 = 0;
    int a1 = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      s0.valid = 1'b1; s0.we = 1'b0; s0.addr = 32'(a0 * 8);
      s1.valid = 1'b1; s1.we = 1'b0; s1.addr = 32'(a1 * 8 + 4);
`ifdef DMEM_ARB_RR_EN
      exp_g = k % 2;
`else
      exp_g = 0;
`endif
      @(negedge clk);
      n_cmp++; if (s0.ready !== (exp_g == 0) || s1.ready !== (exp_g == 1)) begin n_err++; $display("FAIL t4_grant%0d got=%b%b exp_slot=%0d", k, s0.ready, s1.ready, exp_g); end
`ifdef DMEM_ARB_RR_EN
      run0 = stall0 ? run0 + 1 : 0;
      run1 = stall1 ? run1 + 1 : 0;
      n_cmp++; if (run0 > 1 || run1 > 1) begin n_err++; $display("FAIL t4_starve%0d got=%0d/%0d exp<=1", k, run0, run1); end
`endif
      if (exp_g == 0) a0++; else a1++;
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    s0.valid = 1'b1; s0.we = 1'b1; s0.addr = 32'h80; s0.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (s0.ready !== 1'b1) begin n_err++; $display("FAIL t5_accept got=%b exp=1", s0.ready); end
    @(posedge clk); #1;
    s0.valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_we, busy, s0.rsp_valid, s1.rsp_valid} !== 4'b0) begin n_err++; $display("FAIL t5_flush got=%b exp=0000", {mem_we, busy, s0.rsp_valid, s1.rsp_valid}); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || s0.rsp_rdata !== 32'd0) begin n_err++; $display("FAIL t5_zero got=%h/%h/%h exp=0/0/0", mem_addr, mem_wdata, s0.rsp_rdata); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || env_mem[32] !== 32'hA500_0020) begin n_err++; $display("FAIL t5_no_write got=%b/%h exp=0/a5000020", mem_we, env_mem[32]); end
    reset = 1'b1;
    @(posedge clk); #1;
    s1.valid = 1'b1; s1.we = 1'b0; s1.addr = 32'h80;
    @(negedge clk);
    n_cmp++; if (s1.ready !== 1'b1) begin n_err++; $display("FAIL t5_post_ready got=%b exp=1", s1.ready); end
    @(posedge clk); #1; s1.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h80 || mem_we !== 1'b0 || s1.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t5_post_access got=%h/%b/%b exp=80/0/0", mem_addr, mem_we, s1.rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (s1.rsp_valid !== 1'b1 || s1.rsp_rdata !== 32'hA500_0020) begin n_err++; $display("FAIL t5_post_rsp got=%b/%h exp=1/a5000020", s1.rsp_valid, s1.rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          pend [2];
    logic        we_q [2];
    logic [31:0] addr_q [2];
    logic [31:0] wd_q [2];
    logic [31:0] ref_mem [0:63];
    bit          exp_acc [0:NC+4];
    bit          exp_we [0:NC+4];
    logic [31:0] exp_addr [0:NC+4];
    logic [31:0] exp_wd [0:NC+4];
    bit          exp_rv [2][0:NC+4];
    logic [31:0] exp_rd [2][0:NC+4];
    bit          next_rr = 1'b0;
    int          w;
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = env_mem[i];
    for (int c = 0; c < NC + 5; c++) begin
      exp_acc[c] = 1'b0; exp_we[c] = 1'b0; exp_rv[0][c] = 1'b0; exp_rv[1][c] = 1'b0;
    end
    for (int s = 0; s < 2; s++) begin pend[s] = 1'b0; we_q[s] = 1'b0; addr_q[s] = 32'd0; wd_q[s] = 32'd0; end
    for (int c = 0; c < NC + 3; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (c < NC && !pend[s] && $urandom_range(0, 99) < 65) begin
          pend[s] = 1'b1; we_q[s] = 1'($urandom_range(0, 1)); addr_q[s] = $urandom; wd_q[s] = $urandom;
        end
      end
      s0.valid = pend[0]; s0.we = we_q[0]; s0.addr = addr_q[0]; s0.wdata = wd_q[0];
      s1.valid = pend[1]; s1.we = we_q[1]; s1.addr = addr_q[1]; s1.wdata = wd_q[1];
`ifdef DMEM_ARB_RR_EN
      w = (pend[0] && pend[1]) ? int'(next_rr) : (pend[0] ? 0 : (pend[1] ? 1 : -1));
`else
      w = pend[0] ? 0 : (pend[1] ? 1 : -1);
`endif
      @(negedge clk);
      n_cmp++; if (s0.ready !== (w == 0) || s1.ready !== (w == 1)) begin n_err++; $display("FAIL rnd_grant c=%0d got=%b%b exp_slot=%0d", c, s0.ready, s1.ready, w); end
      n_cmp++; if (stall0 !== (pend[0] && w != 0) || stall1 !== (pend[1] && w != 1)) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b%b", c, stall0, stall1); end
      n_cmp++; if (mem_we !== (exp_acc[c] && exp_we[c])) begin n_err++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem_we, exp_acc[c] && exp_we[c]); end
      if (exp_acc[c]) begin
        n_cmp++; if (mem_addr !== exp_addr[c] || (exp_we[c] && mem_wdata !== exp_wd[c])) begin n_err++; $display("FAIL rnd_bus c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, exp_addr[c], exp_wd[c]); end
      end
      n_cmp++; if (s0.rsp_valid !== exp_rv[0][c] || s1.rsp_valid !== exp_rv[1][c]) begin n_err++; $display("FAIL rnd_rspv c=%0d got=%b%b exp=%b%b", c, s0.rsp_valid, s1.rsp_valid, exp_rv[0][c], exp_rv[1][c]); end
      if (exp_rv[0][c]) begin
        n_cmp++; if (s0.rsp_rdata !== exp_rd[0][c]) begin n_err++; $display("FAIL rnd_rd0 c=%0d got=%h exp=%h", c, s0.rsp_rdata, exp_rd[0][c]); end
      end
      if (exp_rv[1][c]) begin
        n_cmp++; if (s1.rsp_rdata !== exp_rd[1][c]) begin n_err++; $display("FAIL rnd_rd1 c=%0d got=%h exp=%h", c, s1.rsp_rdata, exp_rd[1][c]); end
      end
      n_cmp++; if (busy !== (exp_acc[c] || exp_rv[0][c] || exp_rv[1][c])) begin n_err++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
      if (w >= 0) begin
        rd = we_q[w] ? 32'd0 : ref_mem[addr_q[w][7:2]];
        if (we_q[w]) ref_mem[addr_q[w][7:2]] = wd_q[w];
        exp_acc[c+1] = 1'b1; exp_we[c+1] = we_q[w];
        exp_addr[c+1] = {addr_q[w][31:2], 2'b00}; exp_wd[c+1] = wd_q[w];
        exp_rv[w][c+2] = 1'b1; exp_rd[w][c+2] = rd;
        if (pend[0] && pend[1]) next_rr = ~next_rr;
        pend[w] = 1'b0;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_both_loads();
    test_store_load();
    test_contention();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
